// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared state encoding and port indices for the CPU bus arbiter
package mips_bus_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUS_I = 2'b01,
    BUS_D = 2'b10
  } arb_state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin sharing of one Avalon master between fetch and load/store ports
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata
);
  arb_state_t state, state_nx;
  logic last_grant;
  logic elig_i, elig_d, grant_i, grant_d, done;
  function automatic logic rr_pick_d(input logic ei, input logic ed, input logic last);
    return ed && (!ei || last == PORT_I);
  endfunction
  // a port whose ack is high this cycle is not eligible, so a lingering req is not re-granted
  always_comb begin
    elig_i   = i_req && !i_ack;
    elig_d   = d_req && !d_ack;
    grant_d  = state == IDLE && rr_pick_d(elig_i, elig_d, last_grant);
    grant_i  = state == IDLE && elig_i && !grant_d;
    done     = state != IDLE && !waitrequest;
    state_nx = grant_i ? BUS_I : grant_d ? BUS_D : done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_D;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_nx;
      i_ack <= done && state == BUS_I;
      d_ack <= done && state == BUS_D;
      if (grant_i) begin
        address    <= i_addr;
        read       <= 1'b1;
        write      <= 1'b0;
        byteenable <= '1;
        last_grant <= PORT_I;
      end else if (grant_d) begin
        address    <= d_addr;
        read       <= !d_we;
        write      <= d_we;
        writedata  <= d_wdata;
        byteenable <= d_be;
        last_grant <= PORT_D;
      end else if (done) begin
        read  <= 1'b0;
        write <= 1'b0;
        if (read && state == BUS_I) i_rdata <= readdata;
        if (read && state == BUS_D) d_rdata <= readdata;
      end
    end
  end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: table vectors, corner sequences and a randomized transaction-level model
module tb_mips_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, waitrequest = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, readdata = '0;
  logic [3:0]  d_be = '0;
  logic        i_ack, d_ack, read, write;
  logic [31:0] i_rdata, d_rdata, address, writedata;
  logic [3:0]  byteenable;
  int total = 0, bad = 0;

  mips_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    int          waits;
    bit          ex_rd, ex_wr;
    logic [3:0]  ex_be;
    int          ex_lat;
    logic [31:0] ex_own, ex_oth;
  } vec_t;
  vec_t vt[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    logic got;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    waitrequest = 1'b0;
    step();
    lat = 1;
    chk("strobe_read", read, v.ex_rd);
    chk("strobe_write", write, v.ex_wr);
    chk("strobe_addr", address, v.addr);
    chk("strobe_be", byteenable, v.ex_be);
    if (v.we) chk("strobe_wdata", writedata, v.wdata);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      waitrequest = n < v.waits;
      readdata    = n < v.waits ? $urandom : v.rdata;
      step();
      lat++;
      got = v.is_d ? d_ack : i_ack;
      if (!got) begin
        chk("hold_strobe", {read, write}, {v.ex_rd, v.ex_wr});
        chk("hold_addr", address, v.addr);
        chk("hold_be", byteenable, v.ex_be);
      end
    end
    chk("ack_seen", got, 1);
    chk("latency", lat, v.ex_lat);
    chk("other_ack", v.is_d ? i_ack : d_ack, 0);
    chk("strobe_off", {read, write}, 0);
    chk("own_rdata", v.is_d ? d_rdata : i_rdata, v.ex_own);
    chk("other_rdata", v.is_d ? i_rdata : d_rdata, v.ex_oth);
    i_req = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
    step();
  endtask

  // transaction-level reference for the random phase
  bit          m_busy, m_owner, m_last, m_we, m_iack, m_dack;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  logic [3:0]  m_be;

  task automatic model_update();
    bit pi, pd, ei, ed;
    pi = m_iack; pd = m_dack;
    m_iack = 0; m_dack = 0;
    if (m_busy) begin
      if (!waitrequest) begin
        if (!m_we) begin
          if (m_owner) m_drdata = readdata; else m_irdata = readdata;
        end
        if (m_owner) m_dack = 1; else m_iack = 1;
        m_busy = 0;
      end
    end else begin
      ei = i_req && !pi;
      ed = d_req && !pd;
      if (ei || ed) begin
        m_owner = (ei && ed) ? !m_last : ed;
        m_last  = m_owner;
        m_busy  = 1;
        if (m_owner) begin
          m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
        end else begin
          m_we = 0; m_addr = i_addr; m_be = 4'hF;
        end
      end
    end
  endtask

  task automatic model_check();
    chk("rnd_read", read, m_busy && !m_we);
    chk("rnd_write", write, m_busy && m_we);
    chk("rnd_iack", i_ack, m_iack);
    chk("rnd_dack", d_ack, m_dack);
    chk("rnd_irdata", i_rdata, m_irdata);
    chk("rnd_drdata", d_rdata, m_drdata);
    if (m_busy) begin
      chk("rnd_addr", address, m_addr);
      chk("rnd_be", byteenable, m_be);
      if (m_we) chk("rnd_wdata", writedata, m_wdata);
    end
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'hBFC00000, 32'h0,        32'h24020005, 4'hF, 0, 1'b1, 1'b0, 4'hF, 2, 32'h24020005, 32'h0};
    vt[1] = '{1'b1, 1'b1, 32'h00001004, 32'hDEADBEEF, 32'h55555555, 4'h3, 3, 1'b0, 1'b1, 4'h3, 5, 32'h0,        32'h24020005};
    vt[2] = '{1'b1, 1'b0, 32'h00002000, 32'h0,        32'h12345678, 4'hF, 2, 1'b1, 1'b0, 4'hF, 4, 32'h12345678, 32'h24020005};
    vt[3] = '{1'b0, 1'b0, 32'h00000040, 32'h0,        32'h0000A5A5, 4'h0, 1, 1'b1, 1'b0, 4'hF, 3, 32'h0000A5A5, 32'h12345678};
    vt[4] = '{1'b1, 1'b1, 32'h00003000, 32'h01020304, 32'h77777777, 4'hC, 0, 1'b0, 1'b1, 4'hC, 2, 32'h12345678, 32'h0000A5A5};
    vt[5] = '{1'b1, 1'b0, 32'h00003004, 32'h0,        32'hCAFEF00D, 4'hF, 0, 1'b1, 1'b0, 4'hF, 2, 32'hCAFEF00D, 32'h0000A5A5};

    do_reset();
    chk("rst_strobes", {read, write, i_ack, d_ack}, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_be", byteenable, 0);
    chk("rst_irdata", i_rdata, 0);
    chk("rst_drdata", d_rdata, 0);
    for (int k = 0; k < 6; k++) run_vec(vt[k]);

    // simultaneous requests: I wins after reset, D follows in the cycle after i_ack
    do_reset();
    i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200; readdata = 32'h11;
    step();
    chk("tie1_first", {read, address}, {1'b1, 32'h100});
    step();
    chk("tie1_iack", {i_ack, d_ack}, 2'b10);
    chk("tie1_irdata", i_rdata, 32'h11);
    i_req = 0; readdata = 32'h22;
    step();
    chk("tie1_second", {read, address}, {1'b1, 32'h200});
    step();
    chk("tie1_dack", {i_ack, d_ack}, 2'b01);
    chk("tie1_drdata", d_rdata, 32'h22);
    d_req = 0;
    step();
    i_req = 1; i_addr = 32'h104;
    step(); step();
    chk("solo_iack", i_ack, 1);
    i_req = 0;
    step();
    // after an I-only transaction the next tie goes to D
    i_req = 1; i_addr = 32'h108; d_req = 1; d_addr = 32'h204;
    step();
    chk("tie2_first", {read, address}, {1'b1, 32'h204});
    step();
    chk("tie2_dack", d_ack, 1);
    d_req = 0;
    step();
    chk("tie2_second", {read, address}, {1'b1, 32'h108});
    step();
    chk("tie2_iack", i_ack, 1);
    // lingering i_req through its own ack cycle must not re-grant
    step();
    chk("linger_read", read, 0);
    chk("linger_iack", i_ack, 0);
    i_req = 0;
    step();

    // reset during a stalled write abandons it without an ack
    d_req = 1; d_we = 1; d_addr = 32'h4000; d_wdata = 32'hABCD0123; d_be = 4'hF; waitrequest = 1;
    step();
    chk("mid_write", write, 1);
    step();
    reset = 1;
    step();
    chk("mid_strobes", {read, write}, 0);
    chk("mid_dack", d_ack, 0);
    reset = 0; d_req = 0; waitrequest = 0;
    step();
    chk("mid_noack", {d_ack, write, read}, 0);
    step();
    chk("mid_noack2", d_ack, 0);

    // random traffic against the transaction-level model
    do_reset();
    m_busy = 0; m_last = 1; m_iack = 0; m_dack = 0; m_irdata = 0; m_drdata = 0;
    m_owner = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
    for (int c = 0; c < 3000; c++) begin
      if (i_ack || !i_req) begin
        i_req = $urandom_range(0, 2) == 0;
        i_addr = $urandom;
      end
      if (d_ack || !d_req) begin
        d_req = $urandom_range(0, 2) == 0;
        d_we = $urandom_range(0, 1) == 1;
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
      end
      waitrequest = $urandom_range(0, 4) < 2;
      readdata = $urandom;
      step();
      model_update();
      model_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Shares the single Avalon memory-mapped master of the multicycle CPU between two internal requesters: the instruction-fetch port (I) and the load/store port (D). It latches one request at a time, drives the bus until `waitrequest` drops, and returns read data with a one-cycle acknowledge. When both ports are pending, round-robin arbitration decides the winner. It sits between the CPU core's fetch/memory sequencing and the top-level Avalon pins.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. `byteenable` is `DATA_W/8` bits wide.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `i_req` in 1: fetch request. Held high with stable fields until `i_ack`.
- `i_addr` in ADDR_W: fetch word address.
- `i_ack` out 1: one-cycle pulse; the fetch transaction is complete.
- `i_rdata` out DATA_W: fetched word. Valid with `i_ack`, held until the next `i_ack`.
- `d_req` in 1: data request. Same rules as `i_req`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: write data.
- `d_be` in DATA_W/8: byte enables.
- `d_ack` out 1: one-cycle pulse; the data transaction is complete.
- `d_rdata` out DATA_W: load data. Valid with `d_ack` on reads, held until the next `d_ack` on a read.
- `address` out ADDR_W: Avalon address.
- `read` out 1: Avalon read.
- `write` out 1: Avalon write.
- `writedata` out DATA_W: Avalon write data.
- `byteenable` out DATA_W/8: Avalon byte enables.
- `waitrequest` in 1: slave stall.
- `readdata` in DATA_W: slave read data. Valid in any cycle where `read`=1 and `waitrequest`=0.

## Operation
- States:
  - IDLE: no bus activity.
  - BUS_I: fetch on the bus.
  - BUS_D: data access on the bus.
- **IDLE arbitration.** A port is eligible if its `req`=1 and its `ack` is not high this cycle. A port whose `ack` is high is ignored in that cycle, so a lingering `req` is not re-granted.
  - Only one port eligible: grant it.
  - Both eligible: grant the port not in `last_grant`.
- **On grant:**
  - Capture the winner's fields into the bus registers.
  - For I: `read`=1, `byteenable`=all ones, `write`=0.
  - For D: `read`=~`d_we`, `write`=`d_we`, plus `d_wdata` and `d_be`.
  - Set `last_grant` to the winner.
  - Move to BUS_I or BUS_D.
- **BUS_x.** Bus outputs stay constant while `waitrequest`=1; there is no timeout. On the first edge where `waitrequest`=0:
  - Register `readdata` into `x_rdata` (reads only).
  - Pulse `x_ack` for the next cycle.
  - Drop `read`/`write` to 0.
  - Return to IDLE.
- **Write data.** Writes never update `d_rdata`.
- **Bus ownership.** At most one of `read`/`write` is high, and only in a BUS_x state. I and D transactions never overlap.
- **Reset values.** State IDLE, `last_grant`=D (so I wins the first tie), and 0 on all of: `read`, `write`, `address`, `writedata`, `byteenable`, `i_ack`, `d_ack`, `i_rdata`, `d_rdata`.
- **Reset mid-transaction.** The transaction is abandoned: bus strobes are 0 in the cycle after `reset` is sampled, and no ack is issued. Requesters must re-issue.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- **Minimum latency, `waitrequest`=0:**
  - `req` sampled at edge 0.
  - Bus strobe high in cycle 1.
  - `ack` high in cycle 2.
- **Stalls.** Each `waitrequest`=1 cycle in BUS_x adds one cycle of latency.
- **Ack cycle.** The state is already IDLE and arbitrates in that cycle. A request pending on the other port is granted with its bus strobe in the following cycle, so back-to-back throughput is one transaction per 2 cycles.
- **`readdata` sampling.** Sampled only on the completing edge; values during stall cycles are ignored.
- **Request changes.** Changing a requester's fields while its `req` is high before `ack` is undefined for the requester. The arbiter uses the values captured at grant.

## Structure
- Shared package `mips_bus_pkg` holds:
  - `arb_state_t` enum: IDLE=2'b00, BUS_I=2'b01, BUS_D=2'b10.
  - Port-index constants `PORT_I`=0 and `PORT_D`=1.
- Single module; no sub-module is needed. The round-robin pick is a small combinational function in the same file.

## Test plan
- **Single fetch.** `i_req`=1, `i_addr`=0xBFC00000, `waitrequest`=0, `readdata`=0x24020005.
  - `read`=1 with `address`=0xBFC00000 in cycle 1.
  - `i_ack`=1 with `i_rdata`=0x24020005 in cycle 2; `read`=0 in cycle 2.
- **Stalled write.** `d_req`=1, `d_we`=1, `d_addr`=0x1004, `d_wdata`=0xDEADBEEF, `d_be`=4'b0011, `waitrequest`=1 for 3 cycles.
  - `write` held high with all fields constant for 4 cycles.
  - `d_ack` follows one cycle later; `d_rdata` unchanged.
- **Simultaneous requests after reset.** `i_req`=1 and `d_req`=1 in the same cycle.
  - I is granted first, then D in the cycle after `i_ack`.
  - Repeating the tie then grants D first.
- **Lingering request.** `i_req` still high in the `i_ack` cycle with `d_req`=0.
  - No re-grant of I in that cycle; `read`=0 in the next cycle.
- **Reset mid-transaction.** `reset` asserted during BUS_D with `waitrequest`=1.
  - Next cycle: `read`=`write`=0, `d_ack`=0, state IDLE.
- **Read-data isolation.** `readdata` changes every stall cycle, then 0x12345678 on completion.
  - `d_rdata`=0x12345678.
  - `i_rdata` retains its previous value.
